// File: rtl/regfile_if.sv
// Register-file access bus: two read address/data pairs plus one write port.
interface regfile_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/register_file.sv
// Flop-based register file: 2**ADDR_W x DATA_W, two combinational read ports, one write port.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module register_file #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic      clk,
    input logic      rst_n,
    regfile_if.slave bus
);
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // Per-register storage; a write enable gated by RegWrite keeps X addresses harmless when idle.
    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : gen_reg
        if (i == 0 && ZERO_REG) begin : gen_zero
            assign regs[i] = '0;
        end else begin : gen_flop
            logic [DATA_W-1:0] q;
            logic              we;

            assign we = bus.RegWrite && (bus.WriteRegister == ADDR_W'(i));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (we) begin
                    q <= bus.WriteData;
                end
            end

            assign regs[i] = q;
        end
    end

    // Read port 1; reset forces zero even if forwarding would otherwise apply.
    always_comb begin
        rd1 = regs[bus.ReadRegister1];
`ifdef REGFILE_BYPASS_EN
        if (bus.RegWrite && (bus.ReadRegister1 == bus.WriteRegister) &&
            !(ZERO_REG && (bus.ReadRegister1 == '0))) begin
            rd1 = bus.WriteData;
        end
`endif
        if (!rst_n) begin
            rd1 = '0;
        end
    end

    // Read port 2, identical to port 1.
    always_comb begin
        rd2 = regs[bus.ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        if (bus.RegWrite && (bus.ReadRegister2 == bus.WriteRegister) &&
            !(ZERO_REG && (bus.ReadRegister2 == '0))) begin
            rd2 = bus.WriteData;
        end
`endif
        if (!rst_n) begin
            rd2 = '0;
        end
    end

    assign bus.ReadData1 = rd1;
    assign bus.ReadData2 = rd2;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: array reference model, per-cycle compare, directed literal checks.
module tb_register_file;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned NR = 16;
    localparam bit          ZR = 1'b1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    register_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Reference contents: what each register must hold after the last edge.
    logic [DW-1:0] model [NR];
    initial foreach (model[i]) model[i] = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (model[i]) model[i] = '0;
        end else if (bus.RegWrite === 1'b1 && !(ZR && bus.WriteRegister == '0)) begin
            model[bus.WriteRegister] = bus.WriteData;
        end
    end

    function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
        if (rst_n !== 1'b1) return '0;
        if (BYP && bus.RegWrite === 1'b1 && bus.WriteRegister === a && !(ZR && a == '0))
            return bus.WriteData;
        return model[a];
    endfunction

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%h expected 0x%h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_rd1", bus.ReadData1, expect_rd(bus.ReadRegister1));
            check("cyc_rd2", bus.ReadData2, expect_rd(bus.ReadRegister2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bus.RegWrite      = we;
        bus.WriteRegister = wa;
        bus.WriteData     = wd;
        bus.ReadRegister1 = r1;
        bus.ReadRegister2 = r2;
    endtask

    task automatic chk2(input string nm, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        check({nm, "_rd1"}, bus.ReadData1, e1);
        check({nm, "_rd2"}, bus.ReadData2, e2);
    endtask

    initial begin
        drive(1'b0, '0, '0, '0, '0);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Every address reads zero after reset.
        for (int a = 0; a < int'(NR); a++) begin
            step();
            drive(1'b0, '0, '0, AW'(a), AW'(NR - 1 - a));
            #1 chk2("reset_all", 16'h0000, 16'h0000);
        end

        // Write 15 to R1: old value until the edge (unless forwarded), new value after.
        step();
        drive(1'b1, 4'd1, 16'd15, 4'd1, 4'd1);
        #1 chk2("r1_pre", BYP ? 16'd15 : 16'd0, BYP ? 16'd15 : 16'd0);
        step();
        chk2("r1_post", 16'd15, 16'd15);

        drive(1'b1, 4'd2, 16'd5, 4'd1, 4'd2);
        step();
        chk2("r2_post", 16'd15, 16'd5);

        // Disabled writes leave everything untouched.
        drive(1'b0, 4'd5, 16'd5, 4'd5, 4'd1);
        repeat (3) step();
        chk2("no_we", 16'd0, 16'd15);
        bus.ReadRegister2 = 4'd2;
        #1 check("no_we_r2", bus.ReadData2, 16'd5);

        // Unknown address/data while idle must not corrupt storage.
        drive(1'b0, 'x, 'x, 4'd1, 4'd2);
        repeat (2) step();
        chk2("x_idle", 16'd15, 16'd5);

        // Hard-wired zero register ignores writes and is never forwarded.
        drive(1'b1, 4'd0, 16'hBEEF, 4'd0, 4'd0);
        #1 chk2("zero_pre", 16'h0000, 16'h0000);
        step();
        chk2("zero_post", 16'h0000, 16'h0000);

        // Highest address and an overwrite of R1.
        drive(1'b1, 4'd15, 16'h8001, 4'd15, 4'd0);
        step();
        chk2("r15", 16'h8001, 16'h0000);
        drive(1'b1, 4'd1, 16'h7777, 4'd1, 4'd2);
        #1 chk2("ovw_pre", BYP ? 16'h7777 : 16'd15, 16'd5);
        step();
        chk2("ovw_post", 16'h7777, 16'd5);

        // A few distinct patterns; the per-cycle compare tracks them.
        for (int a = 3; a < 9; a++) begin
            drive(1'b1, AW'(a), DW'(a * 16'h1111), AW'(a - 1), AW'(a));
            step();
        end
        drive(1'b0, '0, '0, 4'd6, 4'd8);
        #1 chk2("pattern", 16'h6666, 16'h8888);

        // Fill R1..R15, then a short mid-cycle reset pulse clears everything at once.
        for (int a = 1; a < int'(NR); a++) begin
            step();
            drive(1'b1, AW'(a), 16'hA5A5, AW'(a), AW'(a));
        end
        step();
        drive(1'b0, '0, '0, 4'd1, 4'd15);
        #1 chk2("filled", 16'hA5A5, 16'hA5A5);
        step();
        rst_n = 1'b0;
        #1 chk2("pulse_now", 16'h0000, 16'h0000);
        drive(1'b0, '0, '0, 4'd7, 4'd8);
        #1 chk2("pulse_mid", 16'h0000, 16'h0000);
        #1 rst_n = 1'b1;
        for (int a = 0; a < int'(NR); a++) begin
            step();
            drive(1'b0, '0, '0, AW'(a), AW'(NR - 1 - a));
            #1 chk2("after_pulse", 16'h0000, 16'h0000);
        end

        // Reset coinciding with a write wins; reads are zero even with forwarding.
        step();
        drive(1'b1, 4'd7, 16'h1234, 4'd7, 4'd7);
        rst_n = 1'b0;
        #1 chk2("rst_vs_wr_pre", 16'h0000, 16'h0000);
        step();
        bus.RegWrite = 1'b0;
        #1 rst_n = 1'b1;
        #1 chk2("rst_vs_wr_post", 16'h0000, 16'h0000);

        // First edge with reset released accepts a write.
        step();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        drive(1'b1, 4'd3, 16'h3C3C, 4'd3, 4'd4);
        step();
        drive(1'b0, '0, '0, 4'd3, 4'd4);
        #1 chk2("first_wr", 16'h3C3C, 16'h0000);

        step();
        step();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
